// File: rtl/dsp_regseq_pkg.sv
// dsp_regseq_pkg: shared widths, idle RAM-port values and the writeback entry type.
package dsp_regseq_pkg;
  localparam int REG_AW = 6;
  localparam int REG_DW = 32;
  localparam int REG_N  = 64;
  localparam logic [REG_AW-1:0] IDLE_ADDR = '0;
  localparam logic [REG_DW-1:0] IDLE_DATA = '0;
  localparam logic IDLE_CLK = 1'b0;
  localparam logic IDLE_NWE = 1'b1;
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/dsp_wbfifo.sv
// dsp_wbfifo: writeback FIFO; caller never pushes when full or pops when empty.
module dsp_wbfifo
  import dsp_regseq_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_push,
  input  wb_entry_t i_din,
  input  logic      i_pop,
  output logic      o_full,
  output logic      o_empty,
  output wb_entry_t o_head
);
  localparam int PW = $clog2(WB_DEPTH);
  wb_entry_t r_mem [WB_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_cnt;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk)
    if (i_push) r_mem[r_wp] <= i_din;
  assign o_full  = r_cnt == (PW+1)'(WB_DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_head  = r_mem[r_rp];
endmodule

// File: rtl/dsp_regseq.sv
// dsp_regseq: register-RAM access sequencer with busy scoreboard and writeback FIFO.
module dsp_regseq
  import dsp_regseq_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              op_req,
  input  logic [REG_AW-1:0] op_srca,
  input  logic [REG_AW-1:0] op_srcb,
  input  logic [REG_AW-1:0] op_dst,
  input  logic              op_wb,
  output logic              op_ack,
  output logic              op_valid,
  output logic [REG_DW-1:0] opa,
  output logic [REG_DW-1:0] opb,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [REG_DW-1:0] wb_data,
  output logic              wb_ready,
  output logic [REG_AW-1:0] aa,
  output logic [REG_AW-1:0] ab,
  output logic [REG_DW-1:0] da,
  output logic [REG_DW-1:0] db,
  output logic              clka,
  output logic              clkb,
  output logic              nwea,
  output logic              nweb,
  input  logic [REG_DW-1:0] qa,
  input  logic [REG_DW-1:0] qb
);
  logic [REG_N-1:0] r_busy;
  logic r_op_valid;
  logic w_full, w_empty, w_issue, w_commit;
  logic [REG_N-1:0] w_set, w_clr;
  wb_entry_t w_head, w_din;
  assign w_din = {wb_addr, wb_data};
  dsp_wbfifo #(.WB_DEPTH(WB_DEPTH)) u_fifo (
    .i_clk  (sys_clk),
    .i_rst  (sys_rst),
    .i_push (wb_valid & ~w_full),
    .i_din  (w_din),
    .i_pop  (w_commit),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_head (w_head)
  );
  // Reset gating keeps the RAM ports idle for the whole reset window.
  assign w_issue  = ~sys_rst & op_req & ~r_busy[op_srca] & ~r_busy[op_srcb]
                  & ~(op_wb & r_busy[op_dst]) & ~w_full;
  assign w_commit = ~sys_rst & ~w_empty & ~w_issue;
  assign w_set = {{(REG_N-1){1'b0}}, w_issue & op_wb} << op_dst;
  assign w_clr = {{(REG_N-1){1'b0}}, w_commit} << w_head.addr;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      r_busy     <= '0;
      r_op_valid <= 1'b0;
    end else begin
      r_busy     <= (r_busy & ~w_clr) | w_set;
      r_op_valid <= w_issue;
    end
  always_comb begin
    aa   = w_issue ? op_srca : IDLE_ADDR;
    ab   = w_issue ? op_srcb : w_commit ? w_head.addr : IDLE_ADDR;
    db   = w_commit ? w_head.data : IDLE_DATA;
    clka = w_issue ? 1'b1 : IDLE_CLK;
    clkb = (w_issue | w_commit) ? 1'b1 : IDLE_CLK;
    nweb = w_commit ? 1'b0 : IDLE_NWE;
  end
  assign nwea     = IDLE_NWE;
  assign da       = IDLE_DATA;
  assign op_ack   = w_issue;
  assign op_valid = r_op_valid;
  assign wb_ready = ~w_full;
  assign opa      = qa;
  assign opb      = qb;
endmodule

// File: tb/tb_dsp_regseq.sv
// tb_dsp_regseq: directed scenarios against a behavioural 64x32 dual-port RAM.
module tb_dsp_regseq;
  logic sys_clk = 1'b0, sys_rst = 1'b1;
  logic op_req = 0, op_wb = 0, op_ack, op_valid;
  logic [5:0] op_srca = 0, op_srcb = 0, op_dst = 0;
  logic [31:0] opa, opb;
  logic wb_valid = 0, wb_ready;
  logic [5:0] wb_addr = 0;
  logic [31:0] wb_data = 0;
  logic [5:0] aa, ab;
  logic [31:0] da, db, qa, qb;
  logic clka, clkb, nwea, nweb;
  logic [31:0] mem [64];
  int passed = 0, total = 0;

  dsp_regseq #(.WB_DEPTH(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .op_req(op_req), .op_srca(op_srca),
    .op_srcb(op_srcb), .op_dst(op_dst), .op_wb(op_wb), .op_ack(op_ack),
    .op_valid(op_valid), .opa(opa), .opb(opb), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready), .aa(aa), .ab(ab),
    .da(da), .db(db), .clka(clka), .clkb(clkb), .nwea(nwea), .nweb(nweb),
    .qa(qa), .qb(qb)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (clka) qa <= mem[aa];
    if (clkb && nweb) qb <= mem[ab];
    if (clkb && !nweb) mem[ab] <= db;
  end

  task automatic test_reset();
    @(negedge sys_clk); #1;
    total++; if (op_valid !== 1'b0) $display("FAIL rst_valid got=%0b exp=0", op_valid); else passed++;
    total++; if (wb_ready !== 1'b1) $display("FAIL rst_ready got=%0b exp=1", wb_ready); else passed++;
    total++; if ({clka, clkb, nwea, nweb} !== 4'b0011) $display("FAIL rst_ctl got=%b exp=0011", {clka, clkb, nwea, nweb}); else passed++;
    total++; if ({aa, ab, da, db} !== 76'd0) $display("FAIL rst_bus got=%h exp=0", {aa, ab, da, db}); else passed++;
    @(negedge sys_clk); sys_rst = 1'b0;
  endtask

  task automatic test_read();
    @(negedge sys_clk); op_req = 1; op_srca = 3; op_srcb = 5; op_dst = 0; op_wb = 0; #1;
    total++; if (op_ack !== 1'b1) $display("FAIL read_ack got=%0b exp=1", op_ack); else passed++;
    total++; if ({aa, ab, clka, clkb, nweb} !== {6'd3, 6'd5, 3'b111}) $display("FAIL read_port got=%h exp=%h", {aa, ab, clka, clkb, nweb}, {6'd3, 6'd5, 3'b111}); else passed++;
    @(negedge sys_clk); op_req = 0; #1;
    total++; if (op_valid !== 1'b1) $display("FAIL read_valid got=%0b exp=1", op_valid); else passed++;
    total++; if ({opa, opb} !== {32'h11111111, 32'h55555555}) $display("FAIL read_data got=%h exp=1111111155555555", {opa, opb}); else passed++;
    @(negedge sys_clk); #1;
    total++; if (op_valid !== 1'b0) $display("FAIL read_valid_drop got=%0b exp=0", op_valid); else passed++;
  endtask

  task automatic test_raw();
    @(negedge sys_clk); op_req = 1; op_srca = 0; op_srcb = 0; op_dst = 7; op_wb = 1; #1;
    total++; if (op_ack !== 1'b1) $display("FAIL raw_issue got=%0b exp=1", op_ack); else passed++;
    for (int i = 1; i <= 3; i++) begin
      @(negedge sys_clk); op_wb = 0; op_srca = 7;
      wb_valid = (i == 3); wb_addr = 7; wb_data = 32'hDEADBEEF; #1;
      total++; if (op_ack !== 1'b0) $display("FAIL raw_stall%0d got=%0b exp=0", i, op_ack); else passed++;
    end
    @(negedge sys_clk); wb_valid = 0; #1;
    total++; if (op_ack !== 1'b0) $display("FAIL raw_commit_ack got=%0b exp=0", op_ack); else passed++;
    total++; if ({nweb, ab, db} !== {1'b0, 6'd7, 32'hDEADBEEF}) $display("FAIL raw_commit got=%h exp=%h", {nweb, ab, db}, {1'b0, 6'd7, 32'hDEADBEEF}); else passed++;
    @(negedge sys_clk); #1;
    total++; if ({op_ack, aa} !== {1'b1, 6'd7}) $display("FAIL raw_reissue got=%h exp=%h", {op_ack, aa}, {1'b1, 6'd7}); else passed++;
    @(negedge sys_clk); op_req = 0; #1;
    total++; if ({op_valid, opa} !== {1'b1, 32'hDEADBEEF}) $display("FAIL raw_data got=%h exp=%h", {op_valid, opa}, {1'b1, 32'hDEADBEEF}); else passed++;
  endtask

  task automatic test_fifo_full();
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk); op_req = 1; op_srca = 1; op_srcb = 2; op_wb = 0;
      wb_valid = 1; wb_addr = 6'(20 + k); wb_data = 32'hA0000000 + k; #1;
      total++; if ({op_ack, wb_ready} !== 2'b11) $display("FAIL full_push%0d got=%b exp=11", k, {op_ack, wb_ready}); else passed++;
    end
    @(negedge sys_clk); wb_valid = 0; #1;
    total++; if ({wb_ready, op_ack} !== 2'b00) $display("FAIL full_block got=%b exp=00", {wb_ready, op_ack}); else passed++;
    total++; if ({nweb, ab, db} !== {1'b0, 6'd20, 32'hA0000000}) $display("FAIL full_drain got=%h exp=%h", {nweb, ab, db}, {1'b0, 6'd20, 32'hA0000000}); else passed++;
    @(negedge sys_clk); #1;
    total++; if ({op_ack, wb_ready, nweb} !== 3'b111) $display("FAIL full_resume got=%b exp=111", {op_ack, wb_ready, nweb}); else passed++;
    @(negedge sys_clk); op_req = 0;
    for (int j = 1; j < 4; j++) begin
      #1;
      total++; if ({nweb, ab} !== {1'b0, 6'(20 + j)}) $display("FAIL full_commit%0d got=%h exp=%h", j, {nweb, ab}, {1'b0, 6'(20 + j)}); else passed++;
      @(negedge sys_clk);
    end
    #1;
    total++; if ({clkb, nweb} !== 2'b01) $display("FAIL full_idle got=%b exp=01", {clkb, nweb}); else passed++;
    total++; if (mem[23] !== 32'hA0000003) $display("FAIL full_ram got=%h exp=a0000003", mem[23]); else passed++;
  endtask

  task automatic test_waw();
    @(negedge sys_clk); op_req = 1; op_srca = 0; op_srcb = 0; op_dst = 9; op_wb = 1; #1;
    total++; if (op_ack !== 1'b1) $display("FAIL waw_issue got=%0b exp=1", op_ack); else passed++;
    for (int i = 1; i <= 3; i++) begin
      @(negedge sys_clk); op_srca = 1; op_srcb = 2;
      wb_valid = (i == 3); wb_addr = 9; wb_data = 32'h99; #1;
      total++; if (op_ack !== 1'b0) $display("FAIL waw_stall%0d got=%0b exp=0", i, op_ack); else passed++;
    end
    @(negedge sys_clk); wb_valid = 0; #1;
    total++; if ({op_ack, nweb, ab} !== {2'b00, 6'd9}) $display("FAIL waw_commit got=%h exp=%h", {op_ack, nweb, ab}, {2'b00, 6'd9}); else passed++;
    @(negedge sys_clk); #1;
    total++; if (op_ack !== 1'b1) $display("FAIL waw_release got=%0b exp=1", op_ack); else passed++;
    @(negedge sys_clk); op_req = 0; wb_valid = 1; wb_addr = 9;
    @(negedge sys_clk); wb_valid = 0; #1;
    total++; if ({nweb, ab} !== {1'b0, 6'd9}) $display("FAIL waw_cleanup got=%h exp=%h", {nweb, ab}, {1'b0, 6'd9}); else passed++;
  endtask

  task automatic test_busy_hold();
    @(negedge sys_clk); op_req = 1; op_srca = 0; op_srcb = 0; op_dst = 12; op_wb = 1;
    wb_valid = 1; wb_addr = 13; wb_data = 32'h13; #1;
    total++; if (op_ack !== 1'b1) $display("FAIL hold_issue got=%0b exp=1", op_ack); else passed++;
    @(negedge sys_clk); op_wb = 0; op_srca = 12; wb_valid = 0; #1;
    total++; if ({op_ack, nweb, ab} !== {2'b00, 6'd13}) $display("FAIL hold_commit got=%h exp=%h", {op_ack, nweb, ab}, {2'b00, 6'd13}); else passed++;
    @(negedge sys_clk); #1;
    total++; if (op_ack !== 1'b0) $display("FAIL hold_busy got=%0b exp=0", op_ack); else passed++;
    @(negedge sys_clk); op_srca = 13; #1;
    total++; if (op_ack !== 1'b1) $display("FAIL hold_unsolicited got=%0b exp=1", op_ack); else passed++;
    @(negedge sys_clk); op_req = 0; wb_valid = 1; wb_addr = 12;
    @(negedge sys_clk); wb_valid = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge sys_clk); op_req = 1; op_srca = 1; op_srcb = 2; op_dst = 30; op_wb = 1;
    wb_valid = 1; wb_addr = 30; wb_data = 32'hBAD0001E; #1;
    total++; if (op_ack !== 1'b1) $display("FAIL mid_issue0 got=%0b exp=1", op_ack); else passed++;
    @(negedge sys_clk); op_wb = 0; wb_addr = 31; wb_data = 32'hBAD0001F; #1;
    total++; if (op_ack !== 1'b1) $display("FAIL mid_issue1 got=%0b exp=1", op_ack); else passed++;
    @(negedge sys_clk); op_req = 0; wb_valid = 0; sys_rst = 1; #1;
    total++; if ({nweb, clkb, clka, wb_ready, op_valid} !== 5'b10010) $display("FAIL mid_in_reset got=%b exp=10010", {nweb, clkb, clka, wb_ready, op_valid}); else passed++;
    @(negedge sys_clk); sys_rst = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({nweb, wb_ready, op_valid} !== 3'b110) $display("FAIL mid_after%0d got=%b exp=110", i, {nweb, wb_ready, op_valid}); else passed++;
      @(negedge sys_clk);
    end
    op_req = 1; op_srca = 30; op_srcb = 31; op_dst = 30; op_wb = 1; #1;
    total++; if (op_ack !== 1'b1) $display("FAIL mid_busy_clear got=%0b exp=1", op_ack); else passed++;
    @(negedge sys_clk); op_req = 0; #1;
    total++; if ({opa, opb} !== {32'h1000001E, 32'h1000001F}) $display("FAIL mid_discard got=%h exp=1000001e1000001f", {opa, opb}); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h10000000 | i;
    mem[3] = 32'h11111111;
    mem[5] = 32'h55555555;
    test_reset();
    test_read();
    test_raw();
    test_fifo_full();
    test_waw();
    test_busy_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
